// File: rtl/misr_ora_pkg.sv
// Shared types and defaults for the misr_ora output response analyzer.
package misr_ora_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] DEF_POLY = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'h00;

endpackage

// File: rtl/misr_ora_misr_reg.sv
// Single MISR: shift-left with polynomial feedback from the MSB, XOR-ing in a
// zero-extended input word. Load (seed) has priority over compaction.
module misr_reg
    import misr_ora_pkg::*;
#(
    parameter int                  SIG_BITS = 8,
    parameter int                  IN_BITS  = 2,
    parameter logic [SIG_BITS-1:0] POLY     = SIG_BITS'(DEF_POLY),
    parameter logic [SIG_BITS-1:0] SEED     = SIG_BITS'(DEF_SEED)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [IN_BITS-1:0]  din,
    output logic [SIG_BITS-1:0] sig
);

    logic [SIG_BITS-1:0] din_ext;
    logic [SIG_BITS-1:0] fb;

    always_comb begin
        din_ext                = '0;
        din_ext[IN_BITS-1:0]   = din;
        fb                     = sig[SIG_BITS-1] ? POLY : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sig <= SEED;
        else if (load)
            sig <= SEED;
        else if (en)
            sig <= {sig[SIG_BITS-2:0], 1'b0} ^ fb ^ din_ext;
    end

endmodule

// File: rtl/misr_ora.sv
// Dual-MISR output response analyzer: compacts faulty and fault-free CUT streams
// and reports a single mismatch verdict. MISR_SIG_OUT_EN adds the SIG debug port.
module misr_ora
    import misr_ora_pkg::*;
#(
    parameter int                  OUT_BITS = 2,
    parameter int                  SIG_BITS = 8,
    parameter logic [SIG_BITS-1:0] POLY     = SIG_BITS'(DEF_POLY),
    parameter logic [SIG_BITS-1:0] SEED     = SIG_BITS'(DEF_SEED)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                START,
    input  logic                EN,
    input  logic                TPG_END,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    output logic                BUSY,
    output logic                DONE,
    output logic                RES
`ifdef MISR_SIG_OUT_EN
    ,
    output logic [SIG_BITS-1:0] SIG
`endif
);

    state_t              state;
    logic [SIG_BITS-1:0] sig_cut;
    logic [SIG_BITS-1:0] sig_ff;
    logic                load;
    logic                shift;

    // DONE lags the DONE state by a cycle, so a START landing in the DONE
    // pulse cycle (state already back in IDLE) must be blocked explicitly.
    assign load  = START && (state == ST_IDLE) && !DONE;
    assign shift = EN && (state == ST_COMPACT);

    misr_reg #(.SIG_BITS(SIG_BITS), .IN_BITS(OUT_BITS), .POLY(POLY), .SEED(SEED)) u_cut (
        .clk(clk), .rst(rst), .load(load), .en(shift), .din(CUT_OP), .sig(sig_cut)
    );

    misr_reg #(.SIG_BITS(SIG_BITS), .IN_BITS(OUT_BITS), .POLY(POLY), .SEED(SEED)) u_ff (
        .clk(clk), .rst(rst), .load(load), .en(shift), .din(FF_OP), .sig(sig_ff)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            RES   <= 1'b0;
        end else begin
            BUSY <= (state == ST_COMPACT) || (state == ST_COMPARE);
            DONE <= (state == ST_DONE);
            case (state)
                ST_IDLE:    if (load) state <= ST_COMPACT;
                ST_COMPACT: if (TPG_END) state <= ST_COMPARE;
                ST_COMPARE: begin
                    RES   <= (sig_cut != sig_ff);
                    state <= ST_DONE;
                end
                ST_DONE:    state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

`ifdef MISR_SIG_OUT_EN
    assign SIG = sig_cut;
`endif

endmodule

// File: doc/misr_ora.md
Name: misr_ora

Overview:
- Signature-based output response analyzer: the compaction/receive end of the TPG pattern stream.
- Two MISRs run in lock-step. One compacts the faulty CUT outputs, the other compacts the fault-free CUT outputs.
- At end-of-test the two signatures are compared and a single pass/fail verdict is produced, replacing per-cycle compare in long LBIST runs.
- Sits beside the mid block and is sequenced by the BIST controller.

Parameters:
- OUT_BITS, 2, width of the CUT_OP and FF_OP vectors.
- SIG_BITS, 8, MISR width; must be >= OUT_BITS and >= 2.
- POLY, 8'h1D, feedback polynomial, SIG_BITS wide; bit i set = tap into bit i.
- SEED, 0, MISR load value on START, SIG_BITS wide.

Ports:
- clk, in, 1, system clock; all state updates on the posedge.
- rst, in, 1, asynchronous, active-low reset.
- START, in, 1, one-cycle pulse: seed both MISRs and begin compaction.
- EN, in, 1, pattern-valid qualifier; compact CUT_OP/FF_OP this cycle.
- TPG_END, in, 1, last pattern is being presented this cycle.
- CUT_OP, in, OUT_BITS, output of the fault-injected CUT.
- FF_OP, in, OUT_BITS, output of the fault-free CUT.
- BUSY, out, 1, high in COMPACT and COMPARE.
- DONE, out, 1, one-cycle pulse: RES is valid.
- RES, out, 1, 1 = signatures differ (fault detected); held until the next START.

Behaviour:
- Reset (rst=0, async): state=IDLE; both signatures=SEED; BUSY=0, DONE=0, RES=0.
- MISR update, per register:
  - sig_next = {sig[SIG_BITS-2:0],1'b0} ^ (sig[SIG_BITS-1] ? POLY : 0) ^ zero_extend(in).
  - Applied only in COMPACT with EN=1; otherwise the signature holds.
- FSM states: IDLE, COMPACT, COMPARE, DONE.
  - IDLE: START=1 loads SEED into both MISRs and moves to COMPACT. No compaction occurs in the START cycle. Loading SEED does not clear RES.
  - COMPACT: each cycle with EN=1, both MISRs update. EN=1 and TPG_END=1 in the same cycle compacts that final vector, then moves to COMPARE. TPG_END=1 with EN=0 moves to COMPARE without compaction.
  - COMPARE: RES <= (sig_cut != sig_ff); move to DONE.
  - DONE: DONE=1 for exactly this cycle; return to IDLE.
- Latency: TPG_END sampled at edge N gives DONE=1 and RES valid in the cycle after edge N+2.
- START while not in IDLE is ignored; no re-seed. START in the DONE cycle is also ignored.
- BUSY is a registered state decode: 1 in COMPACT/COMPARE, 0 in IDLE/DONE.
- Aliasing is accepted: equal signatures from differing streams report RES=0.
- Reset mid-operation returns immediately to IDLE, aborts the run and produces no DONE.

Optional Feature:
- Macro: MISR_SIG_OUT_EN.
- Defined: adds output port SIG [SIG_BITS-1:0] carrying the live faulty-path signature (sig_cut), reset value SEED. Used for golden-signature debug dumps.
- Undefined: the port does not exist and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - FSM state typedef/localparams (IDLE=0, COMPACT=1, COMPARE=2, DONE=3).
  - Default POLY and SEED constants.
- Sub-module misr_reg (clk, rst, load, en, din, sig), parameterised by SIG_BITS, POLY and SEED, instantiated twice: u_cut and u_ff.
- Top-level misr_ora holds the FSM and the compare/result registers.

Test Plan:
- Identical streams: START; 32 vectors with CUT_OP=FF_OP=i[1:0]; TPG_END on the 32nd -> DONE 2 cycles later, RES=0, BUSY falls together with the DONE cycle.
- Single mismatch: as above, but vector 5 has CUT_OP=2'b01, FF_OP=2'b00 -> RES=1 held after DONE, until the next START.
- Known signature (MISR_SIG_OUT_EN, SEED=0): inputs 1,2,3 -> SIG=8'h01, 8'h00, 8'h03. Also SEED=8'h80 with input 0 for one vector -> SIG=8'h1D.
- EN gating and ignored START: EN=0 for 4 mid-run cycles -> signatures unchanged. A START pulse during COMPACT -> no re-seed, final RES unchanged.
- Reset mid-run: drive rst=0 asynchronously between edges during COMPACT -> outputs reset immediately, state IDLE, no DONE pulse. A following full run behaves normally.
- TPG_END with EN=0 -> transition to COMPARE without compaction; DONE after 2 cycles.
